// File: rtl/qspi_flash_reader.sv
// qspi_flash_reader: drives the qspi engine through the flash wake command
// (0xAB) and Quad Output Fast Read (0x6B) bursts, and returns a
// back-pressured byte stream.
module qspi_flash_reader #(
    parameter int unsigned WAKE_CYCLES    = 64,
    parameter int unsigned CS_HIGH_CYCLES = 4,
    parameter int unsigned LEN_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [23:0]          req_addr,
    input  logic [LEN_WIDTH-1:0] req_len,
    output logic [7:0]           rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 rd_last,
    output logic                 done,
    output logic                 busy,
    output logic                 init_done,
    output logic                 flash_cs_n,
    output logic                 qspi_start,
    output logic                 qspi_qio_mode,
    output logic                 qspi_dummy,
    output logic                 qspi_delay_cycle,
    output logic [31:0]          qspi_tx_data,
    output logic [5:0]           qspi_tx_size,
    output logic [3:0]           qspi_rx_size,
    input  logic [7:0]           qspi_rx_data,
    input  logic                 qspi_tx_complete,
    input  logic                 qspi_rx_complete
);

    localparam int unsigned CNT_MAX = (WAKE_CYCLES > CS_HIGH_CYCLES) ? WAKE_CYCLES : CS_HIGH_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        WAKE_CMD, WAKE_WAIT_TX, WAKE_GAP, IDLE, CMD, CMD_WAIT,
        DUMMY, DUMMY_WAIT, DATA, DATA_WAIT, CS_HOLD
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [23:0]          addr;
    logic [LEN_WIDTH-1:0] remaining;
    // One setup cycle in WAKE_CMD/CMD so CS is low a full cycle before start.
    logic                 armed;

    logic wake_last, hold_last, len_one;
    assign wake_last = (cnt == CNT_W'(WAKE_CYCLES - 1));
    assign hold_last = (cnt == CNT_W'(CS_HIGH_CYCLES - 1));
    assign len_one   = (remaining == LEN_WIDTH'(1));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= WAKE_CMD;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            WAKE_CMD:     if (armed) state_nxt = WAKE_WAIT_TX;
            WAKE_WAIT_TX: if (qspi_tx_complete) state_nxt = WAKE_GAP;
            WAKE_GAP:     if (wake_last) state_nxt = IDLE;
            IDLE:         if (req_valid && req_len != '0) state_nxt = CMD;
            CMD:          if (armed) state_nxt = CMD_WAIT;
            CMD_WAIT:     if (qspi_tx_complete) state_nxt = DUMMY;
            DUMMY:        state_nxt = DUMMY_WAIT;
            DUMMY_WAIT:   if (qspi_rx_complete) state_nxt = DATA;
            DATA:         if (!rd_valid) state_nxt = DATA_WAIT;
            DATA_WAIT:    if (qspi_rx_complete) state_nxt = len_one ? CS_HOLD : DATA;
            CS_HOLD:      if (hold_last) state_nxt = IDLE;
            default:      state_nxt = WAKE_CMD;
        endcase
    end

    // Engine command fields and status outputs; non-zero only in start cycles
    always_comb begin
        qspi_start       = 1'b0;
        qspi_qio_mode    = 1'b0;
        qspi_dummy       = 1'b0;
        qspi_delay_cycle = 1'b0;
        qspi_tx_data     = '0;
        qspi_tx_size     = '0;
        qspi_rx_size     = '0;
        req_ready        = (state == IDLE);
        busy             = (state != IDLE);
        case (state)
            WAKE_CMD: if (armed) begin
                qspi_start   = 1'b1;
                qspi_tx_data = {8'hAB, 24'h0};
                qspi_tx_size = 6'd8;
            end
            CMD: if (armed) begin
                qspi_start   = 1'b1;
                qspi_tx_data = {8'h6B, addr};
                qspi_tx_size = 6'd32;
            end
            DUMMY: begin
                qspi_start   = 1'b1;
                qspi_rx_size = 4'd8;
                qspi_dummy   = 1'b1;
            end
            DATA: if (!rd_valid) begin
                qspi_start    = 1'b1;
                qspi_rx_size  = 4'd8;
                qspi_qio_mode = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: chip select, counters, request latch and output byte register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flash_cs_n <= 1'b1;
            armed      <= 1'b0;
            cnt        <= '0;
            addr       <= '0;
            remaining  <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            done       <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            done  <= 1'b0;
            armed <= 1'b0;
            if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
            case (state)
                WAKE_CMD: begin
                    flash_cs_n <= 1'b0;
                    armed      <= !armed;
                end
                WAKE_WAIT_TX: if (qspi_tx_complete) begin
                    flash_cs_n <= 1'b1;
                    cnt        <= '0;
                end
                WAKE_GAP: begin
                    cnt <= cnt + 1'b1;
                    if (wake_last) begin
                        cnt       <= '0;
                        init_done <= 1'b1;
                    end
                end
                IDLE: if (req_valid) begin
                    addr      <= req_addr;
                    remaining <= req_len;
                    if (req_len == '0) done <= 1'b1;
                    else               flash_cs_n <= 1'b0;
                end
                CMD: armed <= !armed;
                DATA_WAIT: if (qspi_rx_complete) begin
                    rd_data   <= qspi_rx_data;
                    rd_valid  <= 1'b1;
                    rd_last   <= len_one;
                    remaining <= remaining - 1'b1;
                    if (len_one) begin
                        flash_cs_n <= 1'b1;
                        cnt        <= '0;
                    end
                end
                CS_HOLD: begin
                    cnt <= cnt + 1'b1;
                    if (hold_last) begin
                        cnt  <= '0;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_flash_reader.sv
// tb_qspi_flash_reader: scoreboard bench with a behavioural qspi engine and
// flash model; expected engine commands and bytes are queued by the stimulus.
module tb_qspi_flash_reader;

    localparam int WAKE    = 64;
    localparam int CSH     = 4;
    localparam int ENG_LAT = 3;

    typedef logic [44:0] cmd_t;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [23:0] req_addr = '0;
    logic [15:0] req_len = '0;
    logic [7:0]  rd_data;
    logic        rd_valid, rd_ready = 1'b1, rd_last;
    logic        done, busy, init_done, flash_cs_n;
    logic        qspi_start, qspi_qio_mode, qspi_dummy, qspi_delay_cycle;
    logic [31:0] qspi_tx_data;
    logic [5:0]  qspi_tx_size;
    logic [3:0]  qspi_rx_size;
    logic [7:0]  qspi_rx_data = '0;
    logic        qspi_tx_complete = 1'b0, qspi_rx_complete = 1'b0;

    int total = 0, bad = 0;
    int done_cnt = 0, start_cnt = 0, byte_cnt = 0, cs_run = 0;
    logic cs_prev = 1'b1, eng_busy = 1'b0, hold_valid = 1'b0;
    logic [8:0] hold_val;
    cmd_t cmd_q[$];
    logic [8:0] sb_q[$];

    qspi_flash_reader #(.WAKE_CYCLES(WAKE), .CS_HIGH_CYCLES(CSH), .LEN_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .done(done), .busy(busy), .init_done(init_done), .flash_cs_n(flash_cs_n),
        .qspi_start(qspi_start), .qspi_qio_mode(qspi_qio_mode), .qspi_dummy(qspi_dummy),
        .qspi_delay_cycle(qspi_delay_cycle), .qspi_tx_data(qspi_tx_data),
        .qspi_tx_size(qspi_tx_size), .qspi_rx_size(qspi_rx_size), .qspi_rx_data(qspi_rx_data),
        .qspi_tx_complete(qspi_tx_complete), .qspi_rx_complete(qspi_rx_complete)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cmd_t mk(input logic qio, input logic dmy, input logic [31:0] tx,
                                input logic [5:0] txs, input logic [3:0] rxs);
        return {qio, dmy, 1'b0, tx, txs, rxs};
    endfunction

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h012345: return 8'hDE;
            24'h012346: return 8'hAD;
            24'h012347: return 8'hBE;
            24'h012348: return 8'hEF;
            default:    return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Behavioural engine + flash: checks each command, answers after ENG_LAT cycles
    initial begin
        cmd_t got;
        logic is_tx, is_qio;
        logic [23:0] ptr;
        ptr = '0;
        forever begin
            @(negedge clk);
            if (reset_n && qspi_start) begin
                got = {qspi_qio_mode, qspi_dummy, qspi_delay_cycle, qspi_tx_data, qspi_tx_size, qspi_rx_size};
                if (cmd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL cmd_unexpected: got %0h expected none", got);
                end else begin
                    chk("engine_cmd", got, cmd_q.pop_front());
                end
                if (qspi_tx_size == 6'd32 && qspi_tx_data[31:24] == 8'h6B) ptr = qspi_tx_data[23:0];
                is_tx  = (qspi_tx_size != 0);
                is_qio = qspi_qio_mode;
                @(posedge clk); #1 eng_busy = 1'b1;
                repeat (ENG_LAT - 1) @(posedge clk);
                #1;
                if (is_tx) qspi_tx_complete = 1'b1;
                else begin
                    qspi_rx_complete = 1'b1;
                    qspi_rx_data = is_qio ? flash_byte(ptr) : 8'hFF;
                    if (is_qio) ptr = ptr + 1'b1;
                end
                @(posedge clk); #1;
                qspi_tx_complete = 1'b0;
                qspi_rx_complete = 1'b0;
                eng_busy = 1'b0;
            end
        end
    end

    // Monitor: output bytes, done pulses, start legality, CS high gaps
    always @(negedge clk) begin
        if (reset_n && rd_valid) begin
            if (hold_valid) chk("rd_hold", {rd_last, rd_data}, hold_val);
            if (rd_ready) begin
                if (sb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_unexpected: got %0h expected none", {rd_last, rd_data});
                end else chk("rd_byte", {rd_last, rd_data}, sb_q.pop_front());
                byte_cnt++;
                hold_valid = 1'b0;
            end else begin
                hold_valid = 1'b1;
                hold_val = {rd_last, rd_data};
            end
        end else hold_valid = 1'b0;
        if (reset_n && done) begin
            done_cnt++;
            chk("done_cs_high", flash_cs_n, 1'b1);
        end
        if (reset_n && qspi_start) begin
            start_cnt++;
            chk("cs_low_at_start", flash_cs_n, 1'b0);
            chk("start_while_busy", eng_busy, 1'b0);
            if (qspi_qio_mode) chk("qio_start_while_valid", rd_valid, 1'b0);
        end
        if (flash_cs_n) cs_run++;
        else begin
            if (cs_prev && init_done) chk("cs_gap_ok", cs_run >= CSH, 1'b1);
            cs_run = 0;
        end
        cs_prev = flash_cs_n;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_wake();
        cmd_q.push_back(mk(1'b0, 1'b0, 32'hAB00_0000, 6'd8, 4'd0));
    endtask

    task automatic push_byte(input logic [7:0] d, input logic last);
        sb_q.push_back({last, d});
    endtask

    task automatic wait_init();
        for (int i = 0; i < 1000 && !init_done; i++) tick();
        chk("init_done", init_done, 1'b1);
        chk("wake_cs_gap", cs_run >= WAKE, 1'b1);
        chk("req_ready_after_init", req_ready, 1'b1);
    endtask

    task automatic issue(input logic [23:0] a, input logic [15:0] n);
        bit ok;
        if (n != 0) begin
            cmd_q.push_back(mk(1'b0, 1'b0, {8'h6B, a}, 6'd32, 4'd0));
            cmd_q.push_back(mk(1'b0, 1'b1, 32'h0, 6'd0, 4'd8));
            for (int i = 0; i < int'(n); i++) cmd_q.push_back(mk(1'b1, 1'b0, 32'h0, 6'd0, 4'd8));
        end
        req_addr = a; req_len = n; req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
        end
        chk("req_accept", ok, 1'b1);
        @(posedge clk); #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 3000 && done_cnt < target; i++) tick();
        tick();
        chk("done_count", done_cnt, target);
    endtask

    task automatic wait_bytes(input int target);
        for (int i = 0; i < 1000 && byte_cnt < target; i++) tick();
        chk("byte_progress", byte_cnt >= target, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        push_wake();
        #12;
        chk("rst_cs_n", flash_cs_n, 1'b1);
        chk("rst_start", qspi_start, 1'b0);
        chk("rst_fields", {qspi_qio_mode, qspi_dummy, qspi_delay_cycle, qspi_tx_data, qspi_tx_size, qspi_rx_size}, '0);
        chk("rst_rd", {rd_valid, rd_last, rd_data}, '0);
        chk("rst_done_init", {done, init_done}, 2'b00);
        chk("rst_ready_busy", {req_ready, busy}, 2'b01);
        tick();
        reset_n = 1'b1;
        wait_init();

        // Basic burst
        push_byte(8'hDE, 0); push_byte(8'hAD, 0); push_byte(8'hBE, 0); push_byte(8'hEF, 1);
        issue(24'h012345, 16'd4);
        wait_done(1);
        chk("sb_empty_1", sb_q.size(), 0);
        chk("cmd_empty_1", cmd_q.size(), 0);

        // Consumer stall after byte 2
        push_byte(8'hDE, 0); push_byte(8'hAD, 0); push_byte(8'hBE, 0); push_byte(8'hEF, 1);
        s0 = byte_cnt;
        issue(24'h012345, 16'd4);
        wait_bytes(s0 + 2);
        rd_ready = 1'b0;
        repeat (5) tick();
        chk("stall_byte_pending", rd_valid, 1'b1);
        s0 = start_cnt;
        repeat (15) tick();
        chk("no_start_in_stall", start_cnt, s0);
        rd_ready = 1'b1;
        wait_done(2);
        chk("sb_empty_2", sb_q.size(), 0);

        // Zero-length request
        s0 = start_cnt;
        req_addr = 24'h000777; req_len = 16'd0; req_valid = 1'b1;
        @(negedge clk);
        chk("len0_ready", req_ready, 1'b1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("len0_done", done, 1'b1);
        chk("len0_cs", flash_cs_n, 1'b1);
        @(negedge clk);
        chk("len0_done_clear", done, 1'b0);
        wait_done(3);
        chk("len0_no_start", start_cnt, s0);

        // Back-to-back requests, second crossing the top of the address space
        push_byte(8'h5A, 0); push_byte(8'h5B, 0); push_byte(8'h58, 1);
        push_byte(8'hA4, 0); push_byte(8'hA5, 0); push_byte(8'h5A, 1);
        issue(24'h000100, 16'd3);
        issue(24'hFFFFFE, 16'd3);
        wait_done(5);
        chk("sb_empty_4", sb_q.size(), 0);

        // Reset in the middle of the data phase
        push_byte(8'hDE, 0); push_byte(8'hAD, 0); push_byte(8'hBE, 0); push_byte(8'hEF, 1);
        s0 = byte_cnt;
        issue(24'h012345, 16'd4);
        wait_bytes(s0 + 1);
        rd_ready = 1'b0;
        for (int i = 0; i < 200 && !rd_valid; i++) tick();
        chk("mid_valid", rd_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_cs", flash_cs_n, 1'b1);
        chk("mid_rst_valid", rd_valid, 1'b0);
        chk("mid_rst_state", {req_ready, busy, init_done}, 3'b010);
        sb_q.delete();
        cmd_q.delete();
        push_wake();
        repeat (4) tick();
        reset_n = 1'b1;
        rd_ready = 1'b1;
        wait_init();
        push_byte(8'hBE, 0); push_byte(8'hEF, 1);
        issue(24'h012347, 16'd2);
        wait_done(6);
        chk("sb_empty_5", sb_q.size(), 0);
        chk("cmd_empty_5", cmd_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
